tag_mem_seq: RTL

Parametrised successor to the tag's fixed 64×16 register ROM. Holds `BANKS` independent banks of `2**ADDR_W` words of `DATA_W` bits, accepts burst-read requests from the tag digital core (bank, start pointer, word count, Gen2-style) and streams words back over a valid/ready handshake. Adds a programming write port and an optional CRC-16 trailer word, so the core needs no memory-side framing logic.

---
 rtl/tag_mem_pkg.sv | 25 ++
 rtl/tag_crc16.sv | 43 ++++
 rtl/tag_mem_seq.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/tag_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tag_mem_pkg
// Desc     : Shared state encoding, CRC-16 constants and depth helper for the
//            tag memory sequencer.
// Revision : 1.0
// ============================================================================
package tag_mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SEND  = 2'd2,
    S_CRC   = 2'd3
  } tag_state_e;

  localparam logic [15:0] CRC16_POLY   = 16'h1021;
  localparam logic [15:0] CRC16_PRESET = 16'hFFFF;

  function automatic int tag_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tag_crc16.sv
`default_nettype none
// ============================================================================
// Module   : tag_crc16
// Desc     : CRC-16/CCITT accumulator, one 16-bit word per enabled cycle, MSB first.
// Revision : 1.0
// ============================================================================
module tag_crc16
  import tag_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        en,
  input  logic [15:0] data,
  output logic [15:0] crc
);

  logic [15:0] crc_q;
  logic [15:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    if (init) begin
      crc_d = CRC16_PRESET;
    end else if (en) begin
      for (int i = 15; i >= 0; i--) begin
        crc_d = {crc_d[14:0], 1'b0} ^ ((crc_d[15] ^ data[i]) ? CRC16_POLY : 16'h0000);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      crc_q <= CRC16_PRESET;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule
`default_nettype wire

// File: rtl/tag_mem_seq.sv
`default_nettype none
// ============================================================================
// Module   : tag_mem_seq
// Desc     : Banked tag memory with burst-read sequencer and program-write port.
//            Define TAG_MEM_CRC_EN to append a CRC-16 trailer word to each burst.
// Revision : 1.0
// ============================================================================
module tag_mem_seq
  import tag_mem_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6,
  parameter int BANKS  = 4,
  parameter int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [BANK_W-1:0] i_req_bank,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [ADDR_W:0]   i_req_len,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic              o_rsp_last,
  input  logic              i_wr_en,
  input  logic [BANK_W-1:0] i_wr_bank,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_err,
  output logic              o_busy
);

  localparam int DEPTH = tag_depth(ADDR_W);
  localparam logic [ADDR_W:0] DEPTH_L = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_L   = {{ADDR_W{1'b0}}, 1'b1};

  localparam logic [1:0] ST_IDLE  = S_IDLE;
  localparam logic [1:0] ST_FETCH = S_FETCH;
  localparam logic [1:0] ST_SEND  = S_SEND;
`ifdef TAG_MEM_CRC_EN
  localparam logic [1:0] ST_CRC   = S_CRC;
`endif

  logic [1:0]        state_q, state_d;
  logic [BANK_W-1:0] bank_q, bank_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;
  logic              wr_err_q;
  logic [ADDR_W:0]   len_eff;
  logic              req_hs;
  logic [DATA_W-1:0] mem_q [BANKS][DEPTH];

  assign o_busy      = (state_q != ST_IDLE);
  assign o_req_ready = (state_q == ST_IDLE) && !i_wr_en;
  assign req_hs      = o_req_ready && i_req_valid;
  assign o_rsp_last  = last_q;
  assign o_wr_err    = wr_err_q;

`ifdef TAG_MEM_CRC_EN
  logic [15:0] crc_w;

  tag_crc16 u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .init  (req_hs),
    .en    ((state_q == ST_SEND) && i_rsp_ready),
    .data  (data_q),
    .crc   (crc_w)
  );

  assign o_rsp_valid = (state_q == ST_SEND) || (state_q == ST_CRC);
  assign o_rsp_data  = (state_q == ST_CRC) ? ~crc_w : data_q;
`else
  assign o_rsp_valid = (state_q == ST_SEND);
  assign o_rsp_data  = data_q;
`endif

  // Zero length reads to end of bank; oversize lengths clamp to one full bank.
  always_comb begin
    if (i_req_len == '0) begin
      len_eff = DEPTH_L - {1'b0, i_req_addr};
    end else if (i_req_len > DEPTH_L) begin
      len_eff = DEPTH_L;
    end else begin
      len_eff = i_req_len;
    end
  end

  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (req_hs) begin
          bank_d  = i_req_bank;
          ptr_d   = i_req_addr;
          cnt_d   = len_eff;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        data_d  = mem_q[bank_q][ptr_q];
`ifdef TAG_MEM_CRC_EN
        last_d  = 1'b0;
`else
        last_d  = (cnt_q == ONE_L);
`endif
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (i_rsp_ready) begin
          ptr_d = ptr_q + 1'b1;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == ONE_L) begin
`ifdef TAG_MEM_CRC_EN
            state_d = ST_CRC;
            last_d  = 1'b1;
`else
            state_d = ST_IDLE;
            last_d  = 1'b0;
`endif
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
`ifdef TAG_MEM_CRC_EN
      ST_CRC: begin
        if (i_rsp_ready) begin
          state_d = ST_IDLE;
          last_d  = 1'b0;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      bank_q   <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      last_q   <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      bank_q   <= bank_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      last_q   <= last_d;
      wr_err_q <= i_wr_en && (state_q != ST_IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int b = 0; b < BANKS; b++) begin
        for (int a = 0; a < DEPTH; a++) begin
          mem_q[b][a] <= '0;
        end
      end
    end else if (i_wr_en && (state_q == ST_IDLE)) begin
      mem_q[i_wr_bank][i_wr_addr] <= i_wr_data;
    end
  end

endmodule
`default_nettype wire
